// File: rtl/tdm_pkg.sv
// tdm_pkg: mode encodings and select-width helper shared by the scan mux files.
package tdm_pkg;
  localparam logic MODE_MANUAL = 1'b0;
  localparam logic MODE_SCAN = 1'b1;
  function automatic int sel_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/tdm_scan_ptr.sv
// tdm_scan_ptr: channel pointer with range-checked manual load and wrap at N_CH-1.
import tdm_pkg::*;
module tdm_scan_ptr #(
  parameter int N_CH = 16,
  localparam int SEL_W = sel_w(N_CH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_sel,
  input  logic [SEL_W-1:0] sel_in,
  input  logic             adv,
  output logic [SEL_W-1:0] ptr
);
  localparam logic [SEL_W-1:0] LAST = SEL_W'(N_CH - 1);
  localparam logic [SEL_W:0] LIM = (SEL_W + 1)'(N_CH);
  logic ok;
  assign ok = {1'b0, sel_in} < LIM;
  always_ff @(posedge clk) begin
    if (reset) ptr <= '0;
    else if (load_sel) ptr <= ok ? sel_in : ptr;
    else if (adv) ptr <= (ptr == LAST) ? '0 : ptr + SEL_W'(1);
  end
endmodule

// File: rtl/tdm_scan_mux.sv
// tdm_scan_mux: registered N_CH x W mux with round-robin scanner and valid/ready output.
// Optional per-channel scan mask enabled by defining TDM_SCAN_MASK_EN.
import tdm_pkg::*;
module tdm_scan_mux #(
  parameter int N_CH = 16,
  parameter int W = 1,
  localparam int SEL_W = sel_w(N_CH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic              mode,
  input  logic [SEL_W-1:0]  sel_in,
  input  logic              load_sel,
  input  logic [N_CH*W-1:0] d,
`ifdef TDM_SCAN_MASK_EN
  input  logic [N_CH-1:0]   ch_mask,
`endif
  output logic [W-1:0]      out_data,
  output logic [SEL_W-1:0]  out_ch,
  output logic              out_valid,
  input  logic              out_ready
);
  logic [W-1:0] lane [N_CH];
  logic [SEL_W-1:0] ptr;
  logic scan, free, gate, cap;
  for (genvar i = 0; i < N_CH; i++) begin : g_lane
    assign lane[i] = d[i*W +: W];
  end
  assign scan = mode == MODE_SCAN;
  assign free = !out_valid || out_ready;
`ifdef TDM_SCAN_MASK_EN
  // A masked channel in scan mode looks like en=0 but still lets the pointer move on.
  assign gate = en && !(scan && !ch_mask[ptr]);
`else
  assign gate = en;
`endif
  assign cap = gate && free;
  tdm_scan_ptr #(.N_CH(N_CH)) u_ptr (
    .clk(clk),
    .reset(reset),
    .load_sel(load_sel),
    .sel_in(sel_in),
    .adv(scan && en && free),
    .ptr(ptr)
  );
  always_ff @(posedge clk) begin
    if (reset) begin
      out_data <= '0;
      out_ch <= '0;
      out_valid <= 1'b0;
    end else if (cap) begin
      out_data <= lane[ptr];
      out_ch <= ptr;
      out_valid <= 1'b1;
    end else if (free) begin
      out_valid <= 1'b0;
    end
  end
endmodule
